conv_buf_stage_ctrl: RTL and testbench

- Parametrised address/handshake controller for one operand stream (weight, input or output-readback) of the convolution engine.
- Streams file data into a circular off-chip staging buffer, moves it tile-by-tile into a small on-chip buffer, then serves each tile to the PE array REUSE+1 times.
- Tracks per-entry valid bits, handles non-power-of-two depths, partial last tile and back-pressure.
- Instantiated once per operand stream.

---
 rtl/conv_buf_pkg.sv | 20 ++
 rtl/conv_wrap_ptr.sv | 26 ++
 rtl/conv_buf_stage_ctrl.sv | 186 ++++++++++++++++++
 tb/tb_conv_buf_stage_ctrl.sv | 298 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/conv_buf_pkg.sv
// rtl/conv_buf_pkg.sv - shared FSM state encoding and wrap-increment helper for the staging controller
package conv_buf_pkg;

  localparam int PTR_MAX_W = 16;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_FLUSH = 3'd2,
    ST_SERVE = 3'd3,
    ST_FIN   = 3'd4
  } state_t;

  // Next pointer value: step by one, returning to zero after 'last' (works for any depth).
  function automatic logic [PTR_MAX_W-1:0] wrap_inc(input logic [PTR_MAX_W-1:0] ptr,
                                                    input logic [PTR_MAX_W-1:0] last);
    return (ptr == last) ? '0 : ptr + PTR_MAX_W'(1);
  endfunction

endpackage

// File: rtl/conv_wrap_ptr.sv
// rtl/conv_wrap_ptr.sv - address pointer with enable, synchronous clear and explicit wrap limit
module conv_wrap_ptr
  import conv_buf_pkg::*;
#(
  parameter int AW = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr,
  input  logic          en,
  input  logic [AW-1:0] last,
  output logic [AW-1:0] ptr
);

  // Pointer register: clear has priority over advance; wraps after 'last'.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ptr <= '0;
    end else if (clr) begin
      ptr <= '0;
    end else if (en) begin
      ptr <= AW'(wrap_inc(PTR_MAX_W'(ptr), PTR_MAX_W'(last)));
    end
  end

endmodule

// File: rtl/conv_buf_stage_ctrl.sv
// rtl/conv_buf_stage_ctrl.sv - off-chip staging / on-chip tile controller; CONV_BUF_STAGE_STATS_EN adds stall counters
module conv_buf_stage_ctrl
  import conv_buf_pkg::*;
#(
  parameter int OFF_DEPTH = 147,
  parameter int ON_DEPTH  = 7,
  parameter int OFF_AW    = 9,
  parameter int ON_AW     = 3,
  parameter int LEN_W     = 10,
  parameter int RW        = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [LEN_W-1:0]  xfer_len,
  input  logic [RW-1:0]     reuse_cnt,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              off_wen,
  output logic [OFF_AW-1:0] off_waddr,
  output logic              off_ren,
  output logic [OFF_AW-1:0] off_raddr,
  output logic              on_wen,
  output logic [ON_AW-1:0]  on_waddr,
  input  logic              pe_req,
  output logic              on_ren,
  output logic [ON_AW-1:0]  on_raddr,
  output logic              pe_dvalid,
  output logic              busy,
  output logic              done
`ifdef CONV_BUF_STAGE_STATS_EN
  ,
  output logic [LEN_W-1:0]  stall_empty_cnt,
  output logic [LEN_W-1:0]  stall_full_cnt
`endif
);

  localparam logic [OFF_AW:0]   OFF_FULL = (OFF_AW+1)'(OFF_DEPTH);
  localparam logic [OFF_AW:0]   OFF_ONE  = (OFF_AW+1)'(1);
  localparam logic [OFF_AW-1:0] OFF_LAST = OFF_AW'(OFF_DEPTH - 1);
  localparam logic [LEN_W-1:0]  LEN_ONE  = LEN_W'(1);
  localparam logic [LEN_W-1:0]  TILE_MAX = LEN_W'(ON_DEPTH);

  state_t state_q, state_d;

  logic [LEN_W-1:0]  len_q, wr_total, rd_total;
  logic [LEN_W-1:0]  tile_len, tile_rd, remaining, tile_next;
  logic [RW-1:0]     reuse_q, pass_q;
  logic [OFF_AW:0]   off_count;
  logic [OFF_DEPTH-1:0] valid_q;
  logic              valid_rd;
  logic              start_acc, load_entry, last_rd, pass_end, last_pass;
  logic [ON_AW-1:0]  tile_last;

  assign busy      = (state_q != ST_IDLE);
  assign done      = (state_q == ST_FIN);
  assign start_acc = (state_q == ST_IDLE) && start;
  assign in_ready  = busy && (off_count < OFF_FULL) && (wr_total < len_q);
  assign off_wen   = in_valid && in_ready;
  assign off_ren   = (state_q == ST_LOAD) && valid_rd && (tile_rd < tile_len);
  assign on_ren    = (state_q == ST_SERVE) && pe_req;
  assign tile_last = ON_AW'(tile_len - LEN_ONE);
  assign last_rd   = off_ren && (tile_rd == tile_len - LEN_ONE);
  assign pass_end  = on_ren && (on_raddr == tile_last);
  assign last_pass = (pass_q == reuse_q);
  // A new job sizes its first tile from the live input; later tiles from what is left to read.
  assign remaining = (state_q == ST_IDLE) ? xfer_len : (len_q - rd_total);
  assign tile_next = (remaining < TILE_MAX) ? remaining : TILE_MAX;
  assign load_entry = (state_d == ST_LOAD) && (state_q != ST_LOAD);

  // Valid bit of the entry under the read pointer.
  always_comb begin
    valid_rd = 1'b0;
    for (int i = 0; i < OFF_DEPTH; i++) begin
      if (off_raddr == OFF_AW'(i)) valid_rd = valid_q[i];
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (start) state_d = (xfer_len == '0) ? ST_FIN : ST_LOAD;
      ST_LOAD:  if (last_rd) state_d = ST_FLUSH;
      ST_FLUSH: state_d = ST_SERVE;
      ST_SERVE: if (pass_end && last_pass) state_d = (rd_total < len_q) ? ST_LOAD : ST_FIN;
      ST_FIN:   state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= ST_IDLE;
    else      state_q <= state_d;
  end

  // Job, tile and pass bookkeeping plus the one-cycle delayed strobes.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      len_q     <= '0;
      reuse_q   <= '0;
      wr_total  <= '0;
      rd_total  <= '0;
      tile_len  <= '0;
      tile_rd   <= '0;
      pass_q    <= '0;
      off_count <= '0;
      on_wen    <= 1'b0;
      pe_dvalid <= 1'b0;
    end else begin
      if (start_acc) begin
        len_q    <= xfer_len;
        reuse_q  <= reuse_cnt;
        wr_total <= '0;
        rd_total <= '0;
      end else begin
        if (off_wen) wr_total <= wr_total + LEN_ONE;
        if (off_ren) rd_total <= rd_total + LEN_ONE;
      end
      if (load_entry) begin
        tile_len <= tile_next;
        tile_rd  <= '0;
      end else if (off_ren) begin
        tile_rd  <= tile_rd + LEN_ONE;
      end
      if (load_entry)    pass_q <= '0;
      else if (pass_end) pass_q <= last_pass ? '0 : pass_q + RW'(1);
      case ({off_wen, off_ren})
        2'b10:   off_count <= off_count + OFF_ONE;
        2'b01:   off_count <= off_count - OFF_ONE;
        default: off_count <= off_count;
      endcase
      on_wen    <= off_ren;
      pe_dvalid <= on_ren;
    end
  end

  // Per-entry valid bitmap: set on write, cleared on read; a read never targets the entry being written.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid_q <= '0;
    end else begin
      for (int i = 0; i < OFF_DEPTH; i++) begin
        if (start_acc)                              valid_q[i] <= 1'b0;
        else if (off_wen && off_waddr == OFF_AW'(i)) valid_q[i] <= 1'b1;
        else if (off_ren && off_raddr == OFF_AW'(i)) valid_q[i] <= 1'b0;
      end
    end
  end

  conv_wrap_ptr #(.AW(OFF_AW)) u_off_wptr (
    .clk (clk), .rst (rst), .clr (start_acc), .en (off_wen), .last (OFF_LAST), .ptr (off_waddr)
  );

  conv_wrap_ptr #(.AW(OFF_AW)) u_off_rptr (
    .clk (clk), .rst (rst), .clr (start_acc), .en (off_ren), .last (OFF_LAST), .ptr (off_raddr)
  );

  conv_wrap_ptr #(.AW(ON_AW)) u_on_wptr (
    .clk (clk), .rst (rst), .clr (start_acc), .en (on_wen), .last (tile_last), .ptr (on_waddr)
  );

  conv_wrap_ptr #(.AW(ON_AW)) u_on_rptr (
    .clk (clk), .rst (rst), .clr (start_acc), .en (on_ren), .last (tile_last), .ptr (on_raddr)
  );

`ifdef CONV_BUF_STAGE_STATS_EN
  // Saturating stall counters, cleared when a job is accepted.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_empty_cnt <= '0;
      stall_full_cnt  <= '0;
    end else if (start_acc) begin
      stall_empty_cnt <= '0;
      stall_full_cnt  <= '0;
    end else begin
      if ((state_q == ST_LOAD) && !valid_rd && (stall_empty_cnt != '1))
        stall_empty_cnt <= stall_empty_cnt + LEN_ONE;
      if (busy && in_valid && !in_ready && (stall_full_cnt != '1))
        stall_full_cnt <= stall_full_cnt + LEN_ONE;
    end
  end
`endif

endmodule

// File: tb/tb_conv_buf_stage_ctrl.sv
// tb/tb_conv_buf_stage_ctrl.sv - self-checking bench for conv_buf_stage_ctrl (table jobs, random jobs, abort)
module tb_conv_buf_stage_ctrl;

  localparam int OFF_DEPTH = 147;
  localparam int ON_DEPTH  = 7;
  localparam int OFF_AW    = 9;
  localparam int ON_AW     = 3;
  localparam int LEN_W     = 10;
  localparam int RW        = 4;

  logic              clk = 1'b0;
  logic              rst;
  logic              start;
  logic [LEN_W-1:0]  xfer_len;
  logic [RW-1:0]     reuse_cnt;
  logic              in_valid;
  logic              in_ready;
  logic              off_wen;
  logic [OFF_AW-1:0] off_waddr;
  logic              off_ren;
  logic [OFF_AW-1:0] off_raddr;
  logic              on_wen;
  logic [ON_AW-1:0]  on_waddr;
  logic              pe_req;
  logic              on_ren;
  logic [ON_AW-1:0]  on_raddr;
  logic              pe_dvalid;
  logic              busy;
  logic              done;
`ifdef CONV_BUF_STAGE_STATS_EN
  logic [LEN_W-1:0]  stall_empty_cnt;
  logic [LEN_W-1:0]  stall_full_cnt;
`endif

  conv_buf_stage_ctrl #(
    .OFF_DEPTH (OFF_DEPTH), .ON_DEPTH (ON_DEPTH), .OFF_AW (OFF_AW),
    .ON_AW (ON_AW), .LEN_W (LEN_W), .RW (RW)
  ) dut (
    .clk (clk), .rst (rst), .start (start), .xfer_len (xfer_len), .reuse_cnt (reuse_cnt),
    .in_valid (in_valid), .in_ready (in_ready), .off_wen (off_wen), .off_waddr (off_waddr),
    .off_ren (off_ren), .off_raddr (off_raddr), .on_wen (on_wen), .on_waddr (on_waddr),
    .pe_req (pe_req), .on_ren (on_ren), .on_raddr (on_raddr), .pe_dvalid (pe_dvalid),
    .busy (busy), .done (done)
`ifdef CONV_BUF_STAGE_STATS_EN
    ,
    .stall_empty_cnt (stall_empty_cnt), .stall_full_cnt (stall_full_cnt)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    int len;
    int reuse;
    int im;       // 0: in_valid always, 1: every 4th cycle, 2: random
    int pm;       // 0: pe_req always, 1: random
    int pb;       // cycles pe_req is held low at job start
    int exp_ren;
    bit full;     // job must fill the staging buffer completely
  } vec_t;

  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0;
  bit mon_en = 1'b0;
  bit mdl_busy = 1'b0;
  int job_len, wr_cnt, rd_cnt, onw_cnt, onr_cnt, done_cnt;
  int first_cyc, last_onr_cyc, max_occ, job_base;
  bit seen_first;
  bit prev_off_ren, prev_on_ren;
  int exp_q[$];
  int in_mode, pe_mode, pe_block;
  int drv_k;

  task automatic chk(input string name, input longint act, input longint exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Input driver: in_valid / pe_req patterns, changed 1 time unit after the rising edge.
  initial begin
    in_valid = 1'b0;
    pe_req   = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      drv_k = cyc - job_base;
      case (in_mode)
        0:       in_valid = 1'b1;
        1:       in_valid = (drv_k % 4 == 0);
        default: in_valid = ($urandom_range(0, 1) == 1);
      endcase
      if (drv_k < pe_block)  pe_req = 1'b0;
      else if (pe_mode == 0) pe_req = 1'b1;
      else                   pe_req = ($urandom_range(0, 3) != 0);
    end
  end

  // Reference monitor: stream-level model of one job, sampled on the falling edge.
  initial begin
    forever begin
      @(negedge clk);
      cyc++;
      if (mon_en) begin
        if (!mdl_busy) begin
          chk("idle_busy", busy, 0);
          chk("idle_strobes", {in_ready, off_wen, off_ren, on_wen, on_ren, pe_dvalid, done}, 0);
        end else begin
          if (!seen_first) begin
            seen_first = 1'b1;
            first_cyc  = cyc;
          end
          chk("busy_hi", busy, 1);
          chk("in_ready", in_ready,
              ((wr_cnt - rd_cnt < OFF_DEPTH) && (wr_cnt < job_len)) ? 1 : 0);
          chk("off_wen", off_wen, in_valid & in_ready);
          if (off_wen) chk("off_waddr", off_waddr, wr_cnt % OFF_DEPTH);
          if (off_ren) begin
            chk("off_ren_written", (rd_cnt < wr_cnt) ? 1 : 0, 1);
            chk("off_raddr", off_raddr, rd_cnt % OFF_DEPTH);
          end
          chk("on_wen_lat", on_wen, prev_off_ren);
          if (on_wen) chk("on_waddr", on_waddr, onw_cnt % ON_DEPTH);
          if (on_ren) begin
            chk("on_ren_req", pe_req, 1);
            if (exp_q.size() == 0) begin
              chk("on_ren_extra", 1, 0);
            end else begin
              chk("on_raddr", on_raddr, exp_q[0]);
              void'(exp_q.pop_front());
            end
          end
          chk("pe_dvalid_lat", pe_dvalid, prev_on_ren);
          if (done) begin
            chk("done_dup", done_cnt, 0);
            chk("done_cycle", cyc, (job_len == 0) ? first_cyc : last_onr_cyc + 1);
          end
        end
        if (off_wen) wr_cnt++;
        if (off_ren) rd_cnt++;
        if (on_wen)  onw_cnt++;
        if (on_ren) begin
          onr_cnt++;
          last_onr_cyc = cyc;
        end
        if (wr_cnt - rd_cnt > max_occ) max_occ = wr_cnt - rd_cnt;
        if (done && mdl_busy) begin
          done_cnt++;
          mdl_busy = 1'b0;
        end
        prev_off_ren = off_ren;
        prev_on_ren  = on_ren;
      end else begin
        prev_off_ren = 1'b0;
        prev_on_ren  = 1'b0;
      end
    end
  end

  task automatic run_job(input int len, input int reuse, input int im, input int pm,
                         input int pb, input int exp_ren, input bit full);
    int rem;
    int tl;
    bit got;
    @(posedge clk);
    #1;
    job_len = len; wr_cnt = 0; rd_cnt = 0; onw_cnt = 0; onr_cnt = 0; done_cnt = 0;
    seen_first = 1'b0; last_onr_cyc = -10; max_occ = 0;
    exp_q.delete();
    rem = len;
    while (rem > 0) begin
      tl = (rem < ON_DEPTH) ? rem : ON_DEPTH;
      for (int p = 0; p <= reuse; p++)
        for (int i = 0; i < tl; i++) exp_q.push_back(i);
      rem -= tl;
    end
    in_mode = im; pe_mode = pm; pe_block = pb; job_base = cyc;
    start = 1'b1;
    xfer_len = len[LEN_W-1:0];
    reuse_cnt = reuse[RW-1:0];
    @(posedge clk);
    #1;
    start = 1'b0;
    mdl_busy = 1'b1;
    got = 1'b0;
    for (int i = 0; i < 6000; i++) begin
      @(negedge clk);
      #1;
      if (done_cnt > 0) begin
        got = 1'b1;
        break;
      end
    end
    chk("done_seen", got, 1);
    if (!got) begin
      mon_en = 1'b0;
      rst = 1'b0;
      @(posedge clk);
      #1;
      rst = 1'b1;
      mdl_busy = 1'b0;
      mon_en = 1'b1;
    end else begin
      @(negedge clk);
      #1;
      chk("done_once", done_cnt, 1);
      chk("busy_after", busy, 0);
      chk("on_ren_total", onr_cnt, exp_ren);
      chk("on_wen_total", onw_cnt, len);
      chk("off_wen_total", wr_cnt, len);
      chk("off_ren_total", rd_cnt, len);
      chk("raddr_left", exp_q.size(), 0);
      if (full) chk("max_occ", max_occ, OFF_DEPTH);
`ifdef CONV_BUF_STAGE_STATS_EN
      if (im == 1 && len > 0) chk("stall_empty_pos", (stall_empty_cnt > 0) ? 1 : 0, 1);
      if (full) chk("stall_full_pos", (stall_full_cnt > 0) ? 1 : 0, 1);
`endif
    end
  endtask

  vec_t tbl[7];
  bit found;
  int rl, rr;

  initial begin
    tbl[0] = '{14,  0, 0, 0, 0,   14,  1'b0};
    tbl[1] = '{10,  2, 0, 0, 0,   30,  1'b0};
    tbl[2] = '{300, 0, 0, 0, 400, 300, 1'b1};
    tbl[3] = '{9,   1, 1, 0, 0,   18,  1'b0};
    tbl[4] = '{0,   0, 0, 0, 0,   0,   1'b0};
    tbl[5] = '{1,  15, 0, 0, 0,   16,  1'b0};
    tbl[6] = '{7,   3, 2, 1, 0,   28,  1'b0};

    rst = 1'b0; start = 1'b0; xfer_len = '0; reuse_cnt = '0;
    in_mode = 0; pe_mode = 0; pe_block = 0; job_base = 0;
    repeat (3) @(negedge clk);
    chk("rst_outputs", {in_ready, off_wen, off_waddr, off_ren, off_raddr, on_wen, on_waddr,
                        on_ren, on_raddr, pe_dvalid, busy, done}, 0);
`ifdef CONV_BUF_STAGE_STATS_EN
    chk("rst_stats", {stall_empty_cnt, stall_full_cnt}, 0);
`endif
    @(posedge clk);
    #1;
    rst = 1'b1;
    mon_en = 1'b1;

    for (int v = 0; v < 7; v++)
      run_job(tbl[v].len, tbl[v].reuse, tbl[v].im, tbl[v].pm, tbl[v].pb, tbl[v].exp_ren, tbl[v].full);

    // Abort in the middle of LOAD, then a clean job afterwards.
    @(posedge clk);
    #1;
    mon_en = 1'b0;
    in_mode = 0; pe_mode = 0; pe_block = 0; job_base = cyc;
    start = 1'b1; xfer_len = 10'd20; reuse_cnt = 4'd1;
    @(posedge clk);
    #1;
    start = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (off_ren) begin
        found = 1'b1;
        break;
      end
    end
    chk("abort_in_load", found, 1);
    @(posedge clk);
    #2;
    rst = 1'b0;
    #1;
    chk("abort_outputs", {in_ready, off_wen, off_waddr, off_ren, off_raddr, on_wen, on_waddr,
                          on_ren, on_raddr, pe_dvalid, busy, done}, 0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("abort_no_done", done, 0);
    end
    #1;
    rst = 1'b1;
    mdl_busy = 1'b0;
    mon_en = 1'b1;
    run_job(12, 1, 0, 0, 0, 24, 1'b0);

    // Randomised jobs against the stream model.
    for (int j = 0; j < 10; j++) begin
      rl = $urandom_range(0, 40);
      rr = $urandom_range(0, 3);
      run_job(rl, rr, 2, 1, $urandom_range(0, 20), rl * (rr + 1), 1'b0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
